// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// LOADER_CHECKSUM_EN adds the trailing checksum byte stage (CHECK state).
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Collects four upstream bytes into one little-endian instruction word.
// Unaffected by LOADER_CHECKSUM_EN; the checksum byte never reaches this block.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_strobe,
  input  logic [7:0]  byte_data,
  output logic [31:0] packed_word,
  output logic        word_complete
);

  logic [1:0]  byte_count;
  logic [31:0] assembly_reg;

  // The incoming byte is merged into its lane so the full word is visible in the completing cycle.
  always_comb begin
    packed_word = assembly_reg;
    packed_word[{byte_count, 3'b000} +: 8] = byte_data;
  end

  assign word_complete = byte_strobe && (byte_count == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_count   <= '0;
      assembly_reg <= '0;
    end else if (clear) begin
      byte_count   <= '0;
      assembly_reg <= '0;
    end else if (byte_strobe) begin
      byte_count   <= byte_count + 2'd1;
      assembly_reg <= packed_word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into instruction memory words, holding the core until loading ends.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int data_bits    = 32,
  parameter int memory_depth = 256,
  parameter int address_bits = $clog2(memory_depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [address_bits:0]   word_count,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    mem_write_enable,
  output logic [address_bits-1:0] mem_address,
  output logic [data_bits-1:0]    mem_data,
  output logic                    busy,
  output logic                    done,
  output logic                    core_hold,
  output logic                    checksum_error
);

  localparam logic [address_bits:0] DEPTH_COUNT = (address_bits + 1)'(memory_depth);

  loader_state_t state, next_state;

  logic [address_bits-1:0] word_index;
  logic [address_bits-1:0] last_index;
  logic [address_bits:0]   effective_count;
  logic                    start_accept;
  logic                    start_load;
  logic                    byte_fire;
  logic                    packer_strobe;
  logic                    word_complete;
  logic                    words_remain;
  logic [31:0]             packed_word;

  assign effective_count = (word_count > DEPTH_COUNT) ? DEPTH_COUNT : word_count;
  assign start_accept    = start && ((state == IDLE) || (state == DONE));
  assign start_load      = start_accept && (effective_count != '0);
  assign byte_fire       = byte_valid && byte_ready;
  assign packer_strobe   = byte_fire && (state == RECEIVE);
  assign words_remain    = (word_index != last_index);

  byte_packer u_byte_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_load),
    .byte_strobe  (packer_strobe),
    .byte_data    (byte_data),
    .packed_word  (packed_word),
    .word_complete(word_complete)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state       = state;
    byte_ready       = 1'b0;
    mem_write_enable = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    core_hold        = 1'b1;
    case (state)
      IDLE: begin
        if (start_accept) next_state = start_load ? RECEIVE : DONE;
      end
      RECEIVE: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (word_complete) next_state = WRITE;
      end
      WRITE: begin
        busy             = 1'b1;
        mem_write_enable = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        next_state = words_remain ? RECEIVE : CHECK;
`else
        next_state = words_remain ? RECEIVE : DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) next_state = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start_accept) next_state = start_load ? RECEIVE : DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The memory bus only moves as a word completes, so it is stable for the whole WRITE cycle and after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_index  <= '0;
      last_index  <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      if (start_load) begin
        word_index <= '0;
        last_index <= address_bits'(effective_count - 1'b1);
      end
      if (packer_strobe && word_complete) begin
        mem_address <= word_index;
        mem_data    <= data_bits'(packed_word);
      end
      if ((state == WRITE) && words_remain) word_index <= word_index + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_sum;
  logic [7:0] checksum_total;
  logic       checksum_flag;

  assign checksum_total = checksum_sum + byte_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_sum  <= '0;
      checksum_flag <= 1'b0;
    end else if (start_load) begin
      checksum_sum  <= '0;
      checksum_flag <= 1'b0;
    end else if (packer_strobe) begin
      checksum_sum  <= checksum_total;
    end else if ((state == CHECK) && byte_fire) begin
      checksum_flag <= (checksum_total != 8'h00);
    end
  end

  assign checksum_error = checksum_flag;
`else
  assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as loads are issued.
// Exercises the trailing checksum byte when built with LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam int DEPTH = 256;
  localparam int AB    = 8;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [AB-1:0] addr;
    logic [31:0]   data;
  } write_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AB:0]   word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          mem_write_enable;
  logic [AB-1:0] mem_address;
  logic [31:0]   mem_data;
  logic          busy;
  logic          done;
  logic          core_hold;
  logic          checksum_error;

  write_t        expected_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            write_count = 0;
  logic [AB-1:0] last_addr = '0;

  program_loader #(.data_bits(32), .memory_depth(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .word_count      (word_count),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .busy            (busy),
    .done            (done),
    .core_hold       (core_hold),
    .checksum_error  (checksum_error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_write_enable === 1'b1) begin
      write_t w;
      write_count++;
      last_addr = mem_address;
      check_output("byte_ready_in_write", 32'(byte_ready), 32'd0);
      if (expected_q.size() == 0) begin
        check_output("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = expected_q.pop_front();
        check_output("write_addr", 32'(mem_address), 32'(w.addr));
        check_output("write_data", mem_data, w.data);
      end
    end
  end

  task automatic pulse_start(input int count);
    start      = 1'b1;
    word_count = (AB + 1)'(count);
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check_output("byte_ready_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_output("done", 32'(done), 32'd1);
  endtask

  // gap_mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles.
  task automatic apply_stimulus(input int count, input byte_q_t bytes, input int gap_mode,
                                input bit bad_check, input bit busy_start);
    int         eff = (count > DEPTH) ? DEPTH : count;
    logic [7:0] sum = 8'h00;
    logic [7:0] check_byte;
    bit         gap;
    while (bytes.size() < eff * 4) bytes.push_back(8'($urandom_range(0, 255)));
    for (int w = 0; w < eff; w++) begin
      write_t e;
      e.addr = AB'(w);
      e.data = 32'd0;
      for (int k = 0; k < 4; k++) e.data = e.data + (32'(bytes[4*w+k]) << (8 * k));
      expected_q.push_back(e);
    end
    pulse_start(count);
    for (int i = 0; i < eff * 4; i++) begin
      gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      send_byte(bytes[i], gap);
      sum = sum + bytes[i];
      if (busy_start && i == 1) pulse_start(3);
    end
`ifdef LOADER_CHECKSUM_EN
    check_byte = 8'h00 - sum - 8'(bad_check);
    send_byte(check_byte, 1'b0);
`else
    check_byte = sum;
`endif
    wait_done();
    check_output("core_hold_after_load", 32'(core_hold), 32'd0);
    check_output("busy_after_load", 32'(busy), 32'd0);
    check_output("pending_writes", 32'(expected_q.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check_output("checksum_error", 32'(checksum_error), 32'(bad_check));
`else
    check_output("checksum_error", 32'(checksum_error), 32'd0);
`endif
  endtask

  task automatic check_reset_values();
    check_output("rst_byte_ready", 32'(byte_ready), 32'd0);
    check_output("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check_output("rst_mem_address", 32'(mem_address), 32'd0);
    check_output("rst_mem_data", mem_data, 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_core_hold", 32'(core_hold), 32'd1);
    check_output("rst_checksum_error", 32'(checksum_error), 32'd0);
  endtask

  initial begin
    byte_q_t bytes;
    int      writes_before;

    #12;
    check_reset_values();
    @(posedge clk); #1;
    reset = 1'b1;

    // Zero-word load goes straight to DONE without touching memory.
    write_count = 0;
    pulse_start(0);
    check_output("zero_done", 32'(done), 32'd1);
    check_output("zero_core_hold", 32'(core_hold), 32'd0);
    @(posedge clk); #1;
    check_output("zero_writes", 32'(write_count), 32'd0);

    bytes = {8'h13, 8'h05, 8'h50, 8'h00};
    apply_stimulus(1, bytes, 0, 1'b0, 1'b0);

    bytes = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    apply_stimulus(2, bytes, 1, 1'b0, 1'b0);

    // Reset in the middle of word 0 must discard the partial word.
    writes_before = write_count;
    pulse_start(1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_values();
    check_output("midload_no_write", 32'(write_count), 32'(writes_before));
    expected_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    bytes = {};
    apply_stimulus(1, bytes, 0, 1'b0, 1'b0);

    // Oversized request clamps to the memory depth.
    write_count = 0;
    apply_stimulus(300, bytes, 0, 1'b0, 1'b0);
    check_output("clamp_write_count", 32'(write_count), 32'd256);
    check_output("clamp_last_addr", 32'(last_addr), 32'd255);

    for (int n = 0; n < 6; n++) begin
      apply_stimulus($urandom_range(1, 6), bytes, 2, 1'b0, n == 0);
    end

`ifdef LOADER_CHECKSUM_EN
    bytes = {8'h01, 8'h02, 8'h03, 8'h04};
    apply_stimulus(1, bytes, 0, 1'b0, 1'b0);
    apply_stimulus(1, bytes, 0, 1'b1, 1'b0);
    apply_stimulus(3, {}, 2, 1'b1, 1'b0);
    apply_stimulus(3, {}, 2, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter data_bits, default 32, instruction word width.
REQ-002 SHALL have parameter memory_depth, default 256, instruction memory depth in words.
REQ-003 SHALL have parameter address_bits, default $clog2(memory_depth), word-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle load request.
REQ-007 SHALL have port word_count  input  address_bits+1  number of words to load, sampled on accepted start.
REQ-008 SHALL have port byte_valid  input  1  upstream byte available.
REQ-009 SHALL have port byte_data  input  8  upstream byte.
REQ-010 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-011 SHALL have port mem_write_enable  output  1  instruction memory write strobe.
REQ-012 SHALL have port mem_address  output  address_bits  instruction memory word address.
REQ-013 SHALL have port mem_data  output  data_bits  instruction word to write.
REQ-014 SHALL have port busy  output  1  high in RECEIVE, WRITE, CHECK.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port core_hold  output  1  high until DONE; holds core in reset.
REQ-017 SHALL have port checksum_error  output  1  checksum mismatch flag.

Function
REQ-018 SHALL implement FSM states IDLE, RECEIVE, WRITE, CHECK, DONE.
REQ-019 SHALL transfer a byte only on a cycle with byte_valid and byte_ready both high; byte_ready SHALL be high only in RECEIVE and CHECK.
REQ-020 SHALL pack bytes little-endian: first byte of a word into bits 7:0, fourth into bits 31:24.
REQ-021 SHALL go RECEIVE->WRITE on the cycle after the fourth byte transfer.
REQ-022 SHALL, in WRITE, assert mem_write_enable for exactly one cycle with the current word index on mem_address and the packed word on mem_data.
REQ-023 SHALL, on leaving WRITE, go to RECEIVE with word index +1 if words remain; otherwise go to CHECK (macro on) or DONE (macro off).
REQ-024 SHALL, in IDLE or DONE, on start with effective count 0, go to DONE with no writes; with count >0, go to RECEIVE with index 0, clearing done and checksum_error.
REQ-025 SHALL clamp word_count above memory_depth to memory_depth; mem_address SHALL never exceed memory_depth-1.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL hold mem_address and mem_data stable outside WRITE; SHALL keep partially received bytes across byte_valid gaps.
REQ-028 SHALL clear core_hold on entering DONE and set it again on an accepted non-zero start.

Reset
REQ-029 SHALL, on reset low, asynchronously force: state IDLE, byte_ready 0, mem_write_enable 0, mem_address 0, mem_data 0, busy 0, done 0, core_hold 1, checksum_error 0, byte counter 0, checksum accumulator 0.
REQ-030 SHALL discard a partial word on mid-load reset; a subsequent load SHALL start at address 0.

Configuration
REQ-031 SHALL use macro LOADER_CHECKSUM_EN.
REQ-032 With LOADER_CHECKSUM_EN defined: SHALL accumulate an 8-bit modulo-256 sum of all data bytes; in CHECK SHALL accept one extra byte; SHALL set checksum_error if (sum + byte) mod 256 != 0; SHALL then go to DONE.
REQ-033 Without LOADER_CHECKSUM_EN: CHECK state and accumulator SHALL be absent; checksum_error SHALL be tied 0.

Structure
REQ-034 SHALL place the state enum type and constant BYTES_PER_WORD = 4 in shared package loader_pkg.
REQ-035 SHALL instantiate one sub-module byte_packer containing the 2-bit byte counter and 32-bit shift/assembly register with word_complete output.

Verification
REQ-036 SHALL test word_count=1, bytes 0x13,0x05,0x50,0x00 -> one write, mem_address=0, mem_data=0x00500513, then done=1 and core_hold=0.
REQ-037 SHALL test word_count=0 with start -> done=1 the next cycle, no mem_write_enable pulse, core_hold=0.
REQ-038 SHALL test word_count=2 with byte_valid low every other cycle -> writes 0x00000013 at address 0 and 0x00100093 at address 1; byte_ready=0 during each WRITE cycle.
REQ-039 SHALL test reset low after 2 bytes of word 0 -> all outputs at REQ-029 values, no write; a reload of 1 word writes address 0.
REQ-040 SHALL test word_count=300, memory_depth=256 -> exactly 256 writes, last mem_address=255.
REQ-041 SHALL test, with LOADER_CHECKSUM_EN, data bytes 0x01,0x02,0x03,0x04 plus check 0xF6 -> checksum_error=0; with check 0xF5 -> checksum_error=1.
